// File: rtl/knn_local_buf_streamer.sv
// Master-side streamer for a single-port local buffer: writes a burst of stream words
// to addresses 0..L-1, then reads them back in order through a credit-managed skid FIFO.
module knn_local_buf_streamer #(
    parameter int DataWidth    = 256,
    parameter int AddressRange = 2048,
    parameter int AddressWidth = 11,
    parameter int ReadLatency  = 1,
    parameter int FifoDepth    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [AddressWidth:0]   len,
    output logic                    busy,
    output logic                    done,
    input  logic [DataWidth-1:0]    in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DataWidth-1:0]    out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AddressWidth-1:0] mem_address0,
    output logic                    mem_ce0,
    output logic                    mem_we0,
    output logic [DataWidth-1:0]    mem_d0,
    input  logic [DataWidth-1:0]    mem_q0
);

    localparam int CntW = AddressWidth + 1;
    localparam int FpW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int OccW = $clog2(FifoDepth + 1);
    localparam int CrW  = $clog2(FifoDepth + ReadLatency + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILL   = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [CntW-1:0]        len_q, len_d;
    logic [CntW-1:0]        wptr_q, wptr_d;
    logic [CntW-1:0]        rptr_q, rptr_d;
    logic [CntW-1:0]        ocnt_q, ocnt_d;
    logic [ReadLatency-1:0] vld_q, vld_d;
    logic [DataWidth-1:0]   fifo_q [FifoDepth];
    logic [FpW-1:0]         fwr_q, fwr_d;
    logic [FpW-1:0]         frd_q, frd_d;
    logic [OccW-1:0]        fcnt_q, fcnt_d;

    logic [CntW-1:0]        len_sat_s;
    logic [CrW-1:0]         credit_s;
    logic                   wr_hs_s;
    logic                   issue_s;
    logic                   push_s;
    logic                   pop_s;

    function automatic logic [FpW-1:0] fifo_ptr_inc(input logic [FpW-1:0] p);
        if (p == FpW'(FifoDepth - 1)) begin
            return {FpW{1'b0}};
        end else begin
            return p + FpW'(1);
        end
    endfunction

    assign busy      = (state_q == S_FILL) || (state_q == S_DRAIN);
    assign done      = (state_q == S_FINISH);
    assign in_ready  = (state_q == S_FILL);
    assign out_valid = (fcnt_q != {OccW{1'b0}});
    assign out_data  = fifo_q[frd_q];

    assign len_sat_s = (len > CntW'(AddressRange)) ? CntW'(AddressRange) : len;
    assign wr_hs_s   = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign push_s    = (state_q == S_DRAIN) && vld_q[ReadLatency-1];

    // Credits: words still in the read pipe plus words already parked in the FIFO
    always_comb begin
        credit_s = CrW'(fcnt_q);
        for (int i = 0; i < ReadLatency; i++) begin
            credit_s = credit_s + CrW'(vld_q[i]);
        end
    end

    assign issue_s = (state_q == S_DRAIN) && (rptr_q < len_q) && (credit_s < CrW'(FifoDepth));

    // Read-return tracker: one bit per outstanding read, aligned to the memory latency
    always_comb begin
        vld_d    = {ReadLatency{1'b0}};
        vld_d[0] = issue_s;
        for (int i = 1; i < ReadLatency; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Skid FIFO pointer and occupancy update
    always_comb begin
        fwr_d = push_s ? fifo_ptr_inc(fwr_q) : fwr_q;
        frd_d = pop_s ? fifo_ptr_inc(frd_q) : frd_q;
        case ({push_s, pop_s})
            2'b10:   fcnt_d = fcnt_q + OccW'(1);
            2'b01:   fcnt_d = fcnt_q - OccW'(1);
            default: fcnt_d = fcnt_q;
        endcase
    end

    // Job sequencing and address/handshake counters
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        ocnt_d  = ocnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d  = len_sat_s;
                    wptr_d = {CntW{1'b0}};
                    rptr_d = {CntW{1'b0}};
                    ocnt_d = {CntW{1'b0}};
                    if (len == {CntW{1'b0}}) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (wr_hs_s) begin
                    wptr_d = wptr_q + CntW'(1);
                    if (wptr_q == len_q - CntW'(1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_DRAIN: begin
                if (issue_s) begin
                    rptr_d = rptr_q + CntW'(1);
                end else begin
                    rptr_d = rptr_q;
                end
                if (pop_s) begin
                    ocnt_d = ocnt_q + CntW'(1);
                    if (ocnt_q == len_q - CntW'(1)) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Buffer port: a write handshake and a read issue never coincide (FILL vs DRAIN)
    always_comb begin
        if (wr_hs_s) begin
            mem_ce0      = 1'b1;
            mem_we0      = 1'b1;
            mem_address0 = wptr_q[AddressWidth-1:0];
            mem_d0       = in_data;
        end else if (issue_s) begin
            mem_ce0      = 1'b1;
            mem_we0      = 1'b0;
            mem_address0 = rptr_q[AddressWidth-1:0];
            mem_d0       = {DataWidth{1'b0}};
        end else begin
            mem_ce0      = 1'b0;
            mem_we0      = 1'b0;
            mem_address0 = {AddressWidth{1'b0}};
            mem_d0       = {DataWidth{1'b0}};
        end
    end

    // Control state; reset drops any read still in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= {CntW{1'b0}};
            wptr_q  <= {CntW{1'b0}};
            rptr_q  <= {CntW{1'b0}};
            ocnt_q  <= {CntW{1'b0}};
            vld_q   <= {ReadLatency{1'b0}};
            fwr_q   <= {FpW{1'b0}};
            frd_q   <= {FpW{1'b0}};
            fcnt_q  <= {OccW{1'b0}};
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            ocnt_q  <= ocnt_d;
            vld_q   <= vld_d;
            fwr_q   <= fwr_d;
            frd_q   <= frd_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // FIFO storage captures read data as it returns from the buffer
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_q[fwr_q] <= mem_q0;
        end
    end

endmodule

// File: tb/tb_knn_local_buf_streamer.sv
// Randomized bench for knn_local_buf_streamer: a buffer model plus a scoreboard that
// expects the drained words to be exactly the first L accepted fill words, in order.
module tb_knn_local_buf_streamer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [11:0]  len;
    logic         busy, done;
    logic [255:0] in_data;
    logic         in_valid, in_ready;
    logic [255:0] out_data;
    logic         out_valid, out_ready;
    logic [10:0]  mem_address0;
    logic         mem_ce0, mem_we0;
    logic [255:0] mem_d0;
    logic [255:0] mem_q0 = 256'd0;

    logic [255:0] mem_arr [2048];
    logic [255:0] exp_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int wr_idx, rd_idx, out_cnt, done_cnt, first_rd, first_ov;
    bit ce_seen, busy_seen;
    bit mon_en = 1'b0;

    knn_local_buf_streamer dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .mem_address0(mem_address0), .mem_ce0(mem_ce0), .mem_we0(mem_we0),
        .mem_d0(mem_d0), .mem_q0(mem_q0)
    );

    always #5 clk = ~clk;

    // Single-port buffer with one cycle of read latency
    always @(posedge clk) begin
        if (mem_ce0) begin
            if (mem_we0) mem_arr[mem_address0] <= mem_d0;
            else         mem_q0 <= mem_arr[mem_address0];
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: every memory command and every output word, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (mem_ce0) ce_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
            if (done) done_cnt++;
            if (in_valid && in_ready) begin
                chk("wr_cmd", 256'({mem_ce0, mem_we0, mem_address0}), 256'({2'b11, 11'(wr_idx)}));
                chk("wr_data", mem_d0, in_data);
                exp_q.push_back(in_data);
                wr_idx++;
            end else if (mem_ce0) begin
                chk("rd_cmd", 256'({mem_we0, mem_address0}), 256'({1'b0, 11'(rd_idx)}));
                if (first_rd < 0) first_rd = cyc;
                rd_idx++;
                chk("credit", 256'((rd_idx - out_cnt) <= 4), 256'(1'b1));
            end
            if (out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                if (out_ready) begin
                    if (exp_q.size() == 0) chk("out_extra", 256'(1'b1), 256'(1'b0));
                    else chk("out_data", out_data, exp_q.pop_front());
                    out_cnt++;
                end
            end
        end
    end

    // rdy_mode: 1 always ready, 2 pattern 1,0,0,1, 3 random; abort_at<0 disables the reset abort
    task automatic run_job(input int ln, input int rdy_mode, input bit fixed_data,
                           input int pulse_at, input int abort_at);
        int  exp_l, k, nh;
        bit  hs, seen_done, aborted;
        exp_l = (ln > 2048) ? 2048 : ln;
        exp_q.delete();
        wr_idx = 0; rd_idx = 0; out_cnt = 0; done_cnt = 0;
        first_rd = -1; first_ov = -1; ce_seen = 1'b0; busy_seen = 1'b0;
        nh = 0; k = 0; seen_done = 1'b0; aborted = 1'b0;
        @(posedge clk); #1;
        start     = 1'b1;
        len       = 12'(ln);
        in_valid  = fixed_data ? 1'b1 : ($urandom_range(3) != 0);
        in_data   = fixed_data ? 256'hA0 : rnd256();
        out_ready = (rdy_mode == 3) ? 1'($urandom_range(1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        len   = 12'($urandom_range(4095));
        while (!seen_done && !aborted && k < 20000) begin
            @(negedge clk);
            if (k == 0) begin
                chk("busy_after_start", 256'(busy), 256'(exp_l > 0));
                chk("done_after_start", 256'(done), 256'(exp_l == 0));
            end
            hs = in_valid && in_ready;
            seen_done = done;
            @(posedge clk); #1;
            k++;
            if (hs) nh++;
            if (!seen_done) begin
                if (abort_at >= 0 && out_cnt >= abort_at) begin
                    reset = 1'b0;
                    aborted = 1'b1;
                end
                if (k == pulse_at) begin
                    start = 1'b1;
                    len   = 12'd5;
                end else begin
                    start = 1'b0;
                end
                if (hs || !in_valid) begin
                    in_valid = fixed_data ? 1'b1 : ($urandom_range(3) != 0);
                    in_data  = fixed_data ? (256'hA0 + 256'(nh)) : rnd256();
                end
                case (rdy_mode)
                    2:       out_ready = ((k % 4) == 0) || ((k % 4) == 3);
                    3:       out_ready = 1'($urandom_range(1));
                    default: out_ready = 1'b1;
                endcase
            end
        end
        start = 1'b0;
        if (aborted) begin
            @(negedge clk);
            @(negedge clk);
            chk("abort_state", 256'({out_valid, busy, mem_ce0}), 256'(3'b000));
            @(posedge clk); #1;
            reset = 1'b1;
        end else begin
            if (!seen_done) chk("timeout", 256'(1'b0), 256'(1'b1));
            @(negedge clk);
            chk("done_single", 256'({done, busy}), 256'(2'b00));
            chk("done_count", 256'(done_cnt), 256'(1));
            chk("wr_count", 256'(wr_idx), 256'(exp_l));
            chk("rd_count", 256'(rd_idx), 256'(exp_l));
            chk("out_count", 256'(out_cnt), 256'(exp_l));
            chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));
            if (exp_l > 0) begin
                chk("first_out_latency", 256'(first_ov - first_rd), 256'(2));
            end else begin
                chk("len0_no_mem", 256'({ce_seen, busy_seen}), 256'(2'b00));
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; len = 12'd0;
        in_valid = 1'b0; in_data = 256'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 256'({busy, done, in_ready, out_valid, mem_ce0, mem_we0}), 256'(6'd0));
        chk("reset_addr", 256'(mem_address0), 256'(11'd0));
        @(posedge clk); #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        run_job(4, 1, 1'b1, -1, -1);
        run_job(8, 2, 1'b0, -1, -1);
        run_job(0, 1, 1'b0, -1, -1);
        run_job(3000, 3, 1'b0, -1, -1);
        run_job(10, 1, 1'b0, -1, 5);
        run_job(2, 1, 1'b0, -1, -1);
        run_job(12, 3, 1'b0, 3, -1);
        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(40, 1), 3, 1'b0, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
